// File: rtl/aes_pkg.sv
// Shared widths, FSM states and error codes
// for the AES input stream receiver.
package aes_pkg;

  localparam int DATA_W = 128;
  localparam int ID_W   = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    S_TEXT,
    S_KEY,
    S_ISSUE
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_EARLY_LAST  = 2'b01,
    ERR_NO_LAST     = 2'b10,
    ERR_ID_MISMATCH = 2'b11
  } rx_err_t;

endpackage

// File: rtl/aes_stream_rx_if.sv
// Beat stream in, job port out, as seen
// between stream source, receiver and core.
interface aes_stream_rx_if;
  import aes_pkg::*;

  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic [ID_W-1:0]   tid;
  logic [DATA_W-1:0] tdata;
  logic              job_valid;
  logic              job_ready;
  logic [ID_W-1:0]   job_id;
  logic [DATA_W-1:0] job_text;
  logic [DATA_W-1:0] job_key;

  modport master (
    output tvalid, tlast, tid, tdata,
    output job_ready,
    input  tready,
    input  job_valid, job_id,
    input  job_text, job_key
  );

  modport slave (
    input  tvalid, tlast, tid, tdata,
    input  job_ready,
    output tready,
    output job_valid, job_id,
    output job_text, job_key
  );

endinterface

// File: rtl/aes_stream_rx.sv
// Pairs text and key beats into cipher jobs,
// dropping and counting malformed beats.
module aes_stream_rx
  import aes_pkg::*;
#(
  parameter int CNT_W = aes_pkg::CNT_W
) (
  input  logic             sclk,
  input  logic             srst_n,
  aes_stream_rx_if.slave   s,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count
);

  rx_state_t         state_q, state_d;
  logic              tready_q;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] text_q, text_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              pulse_q, pulse_d;
  rx_err_t           code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  rx_err_t           err_kind;
  logic              err_hit;
  logic              accept;

  assign accept = s.tvalid && tready_q;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    text_d   = text_q;
    key_d    = key_q;
    err_hit  = 1'b0;
    err_kind = ERR_NONE;
    unique case (state_q)
      S_TEXT: begin
        if (accept && s.tlast) begin
          err_hit  = 1'b1;
          err_kind = ERR_EARLY_LAST;
        end else if (accept) begin
          text_d  = s.tdata;
          id_d    = s.tid;
          state_d = S_KEY;
        end
      end
      S_KEY: begin
        if (accept && !s.tlast) begin
          // restart the pair on this beat
          err_hit  = 1'b1;
          err_kind = ERR_NO_LAST;
          text_d   = s.tdata;
          id_d     = s.tid;
        end else if (accept) begin
          if (s.tid == id_q) begin
            key_d   = s.tdata;
            state_d = S_ISSUE;
          end else begin
            err_hit  = 1'b1;
            err_kind = ERR_ID_MISMATCH;
            state_d  = S_TEXT;
          end
        end
      end
      S_ISSUE: begin
        if (s.job_ready) state_d = S_TEXT;
      end
      default: state_d = S_TEXT;
    endcase
  end

  always_comb begin
    pulse_d = err_hit;
    code_d  = err_hit ? err_kind : code_q;
    cnt_d   = cnt_q;
    if (err_hit && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q  <= S_TEXT;
      tready_q <= 1'b0;
      id_q     <= '0;
      text_q   <= '0;
      key_q    <= '0;
      pulse_q  <= 1'b0;
      code_q   <= ERR_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d != S_ISSUE);
      id_q     <= id_d;
      text_q   <= text_d;
      key_q    <= key_d;
      pulse_q  <= pulse_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s.tready    = tready_q;
  assign s.job_valid = (state_q == S_ISSUE);
  assign s.job_id    = id_q;
  assign s.job_text  = text_q;
  assign s.job_key   = key_q;
  assign err_pulse   = pulse_q;
  assign err_code    = code_q;
  assign err_count   = cnt_q;

endmodule

// File: tb/tb_aes_stream_rx.sv
// Randomized and directed bench for aes_stream_rx
// against a job-level reference model.
module tb_aes_stream_rx;
  import aes_pkg::*;

  localparam int CW = 2;
  localparam logic [CW-1:0] CMAX = '1;

  logic sclk = 1'b0;
  logic srst_n = 1'b0;
  always #5 sclk = ~sclk;

  aes_stream_rx_if bus();
  logic          err_pulse;
  logic [1:0]    err_code;
  logic [CW-1:0] err_count;

  aes_stream_rx #(.CNT_W(CW)) dut (
    .sclk      (sclk),
    .srst_n    (srst_n),
    .s         (bus),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_count (err_count)
  );

  int total = 0;
  int bad = 0;
  int jobs = 0;

  bit           m_ready, m_has, m_issue, m_pulse;
  logic [127:0] m_text, m_key;
  logic [31:0]  m_id;
  logic [1:0]   m_code;
  logic [CW-1:0] m_cnt;

  localparam logic [127:0] PT =
    128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] KY =
    128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tready", 128'(bus.tready), 128'(m_ready));
    chk("valid", 128'(bus.job_valid), 128'(m_issue));
    chk("id", 128'(bus.job_id), 128'(m_id));
    chk("text", bus.job_text, m_text);
    chk("key", bus.job_key, m_key);
    chk("pulse", 128'(err_pulse), 128'(m_pulse));
    chk("code", 128'(err_code), 128'(m_code));
    chk("count", 128'(err_count), 128'(m_cnt));
  endtask

  task automatic step(input bit tv, input bit tl,
                      input logic [31:0] id,
                      input logic [127:0] d,
                      input bit jr, input bit rst);
    bit n_ready, n_has, n_issue, n_pulse;
    logic [127:0] n_text, n_key;
    logic [31:0] n_id;
    logic [1:0] n_code;
    logic [CW-1:0] n_cnt;
    int e;
    @(negedge sclk);
    check_all();
    bus.tvalid = tv;
    bus.tlast = tl;
    bus.tid = id;
    bus.tdata = d;
    bus.job_ready = jr;
    srst_n = !rst;
    n_ready = m_ready; n_has = m_has;
    n_issue = m_issue; n_pulse = 1'b0;
    n_text = m_text; n_key = m_key;
    n_id = m_id; n_code = m_code;
    n_cnt = m_cnt; e = 0;
    if (rst) begin
      n_ready = 0; n_has = 0; n_issue = 0;
      n_text = '0; n_key = '0; n_id = '0;
      n_code = 2'b00; n_cnt = '0;
    end else if (m_issue) begin
      n_ready = jr;
      if (jr) begin
        n_issue = 0;
        jobs++;
      end
    end else begin
      n_ready = 1;
      if (tv && m_ready) begin
        if (!m_has && tl) e = 1;
        else if (!m_has || !tl) begin
          if (m_has) e = 2;
          n_has = 1; n_text = d; n_id = id;
        end else if (id == m_id) begin
          n_key = d; n_issue = 1;
          n_ready = 0; n_has = 0;
        end else begin
          e = 3; n_has = 0;
        end
      end
    end
    if (e != 0) begin
      n_pulse = 1'b1;
      n_code = 2'(e);
      if (m_cnt != CMAX) n_cnt = m_cnt + 1'b1;
    end
    @(posedge sclk);
    m_ready = n_ready; m_has = n_has;
    m_issue = n_issue; m_pulse = n_pulse;
    m_text = n_text; m_key = n_key;
    m_id = n_id; m_code = n_code;
    m_cnt = n_cnt;
  endtask

  task automatic idle(input int n, input bit jr);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, '0, jr, 0);
  endtask

  task automatic beat(input bit tl,
                      input logic [31:0] id,
                      input logic [127:0] d);
    step(1, tl, id, d, 1, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int j0;
    logic [127:0] a, b, k;
    bus.tvalid = 0; bus.tlast = 0;
    bus.tid = '0; bus.tdata = '0;
    bus.job_ready = 0;
    m_ready = 0; m_has = 0; m_issue = 0;
    m_pulse = 0; m_text = '0; m_key = '0;
    m_id = '0; m_code = 2'b00; m_cnt = '0;

    step(0, 0, 0, '0, 0, 1);
    step(0, 0, 0, '0, 0, 1);
    #1 chk("rst_tready", 128'(bus.tready), 0);
    idle(2, 0);

    // nominal pair, core ready
    j0 = jobs;
    beat(0, 1, PT);
    beat(1, 1, KY);
    #1 chk("nom_valid", 128'(bus.job_valid), 1);
    chk("nom_id", 128'(bus.job_id), 1);
    chk("nom_text", bus.job_text, PT);
    chk("nom_key", bus.job_key, KY);
    idle(2, 1);
    chk("nom_jobs", 128'(jobs - j0), 1);

    // backpressure held five cycles
    beat(0, 7, KY);
    beat(1, 7, PT);
    idle(5, 0);
    #1 chk("bp_tready", 128'(bus.tready), 0);
    chk("bp_text", bus.job_text, KY);
    idle(1, 1);
    #1 chk("bp_release", 128'(bus.tready), 1);
    idle(1, 0);

    // early tlast
    j0 = jobs;
    beat(1, 2, rnd128());
    #1 chk("early_pulse", 128'(err_pulse), 1);
    chk("early_code", 128'(err_code), 1);
    chk("early_cnt", 128'(err_count), 1);
    idle(1, 0);
    #1 chk("early_once", 128'(err_pulse), 0);
    beat(0, 1, PT);
    beat(1, 1, KY);
    idle(2, 1);
    chk("early_jobs", 128'(jobs - j0), 1);

    // missing tlast
    a = rnd128(); b = rnd128(); k = rnd128();
    j0 = jobs;
    beat(0, 3, a);
    beat(0, 3, b);
    #1 chk("nolast_code", 128'(err_code), 2);
    beat(1, 3, k);
    #1 chk("nolast_text", bus.job_text, b);
    chk("nolast_key", bus.job_key, k);
    chk("nolast_cnt", 128'(err_count), 2);
    idle(2, 1);
    chk("nolast_jobs", 128'(jobs - j0), 1);

    // id mismatch, then saturate counter
    j0 = jobs;
    beat(0, 4, rnd128());
    beat(1, 5, rnd128());
    #1 chk("mis_code", 128'(err_code), 3);
    chk("mis_valid", 128'(bus.job_valid), 0);
    chk("mis_tready", 128'(bus.tready), 1);
    beat(1, 6, rnd128());
    beat(1, 6, rnd128());
    #1 chk("sat_cnt", 128'(err_count), 3);
    idle(2, 1);
    chk("mis_jobs", 128'(jobs - j0), 0);

    // reset while a job is pending
    beat(0, 9, rnd128());
    beat(1, 9, rnd128());
    idle(1, 0);
    step(0, 0, 0, '0, 0, 1);
    #1 chk("rst_valid", 128'(bus.job_valid), 0);
    chk("rst_cnt", 128'(err_count), 0);
    chk("rst_key", bus.job_key, 0);
    idle(3, 1);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 4) != 0,
           $urandom % 2,
           32'($urandom % 2),
           rnd128(),
           ($urandom % 10) < 7,
           ($urandom % 250) == 0);
    end
    idle(2, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/aes_stream_rx.md
# aes_stream_rx

Receive side of the AES input stream. Accepts 128-bit beats on the tvalid/tready/tlast/tid/tdata interface, pairs a plaintext beat with the following key beat, and presents each complete (id, text, key) job to the cipher core through a valid/ready job port. Protocol violations are dropped, flagged and counted so the core only ever sees well-formed jobs.

## Interface
- DATA_W, 128, beat and block width in bits
- ID_W, 32, transaction id width
- CNT_W, 16, error counter width
- sclk  in  1  clock; all logic on rising edge
- srst_n  in  1  reset, asynchronous assert, active-low
- tvalid  in  1  beat valid
- tlast  in  1  last beat of job; must be set on the key beat
- tready  out  1  block can accept a beat
- tid  in  ID_W  job id, identical on both beats of a job
- tdata  in  DATA_W  beat payload; byte i at bits [8i+7:8i], passed through unchanged
- job_valid  out  1  job outputs valid
- job_ready  in  1  core accepts job
- job_id  out  ID_W  id of job
- job_text  out  DATA_W  plaintext block
- job_key  out  DATA_W  key block
- err_pulse  out  1  one-cycle flag, protocol error detected
- err_code  out  2  code of last error: 01 early tlast, 10 missing tlast, 11 id mismatch, 00 none since reset
- err_count  out  CNT_W  saturating count of errors

## Operation
- Beat accepted on a rising edge with tvalid && tready.
- FSM states: S_TEXT, S_KEY, S_ISSUE. Reset state S_TEXT.
- S_TEXT: tready=1. Accepted beat with tlast=0 -> capture tdata into text register and tid into id register; go S_KEY. Accepted beat with tlast=1 -> early tlast: beat discarded, err code 01; stay S_TEXT.
- S_KEY: tready=1. Accepted beat with tlast=1 and tid == stored id -> capture key; go S_ISSUE. tlast=1 and tid mismatch -> err code 11, discard pair, go S_TEXT. tlast=0 -> missing tlast: err code 10, beat treated as new text (text and id overwritten), stay S_KEY.
- S_ISSUE: tready=0, job_valid=1, job outputs stable. job_ready=1 -> go S_TEXT. No beat consumed while in S_ISSUE.
- Error reporting: err_pulse high exactly the cycle after the offending edge; err_code updated simultaneously and held; err_count increments by 1, saturates at 2^CNT_W-1.
- job_id/job_text/job_key driven directly from capture registers; only meaningful while job_valid=1.

## Timing
- Reset values: tready=0 during reset, 1 from first cycle after deassert; job_valid=0; job_id/job_text/job_key=0; err_pulse=0; err_code=00; err_count=0.
- Reset mid-job discards partial or pending job; no job_valid after release until two new beats arrive.
- Latency: key accepted at edge N -> job_valid=1 from edge N (visible cycle N+1); job_ready=1 in that cycle -> job_valid=0 and tready=1 the following cycle.
- Best-case throughput: one job per 3 cycles (text, key, issue).
- tready is a registered function of state only; no combinational path tvalid->tready or job_ready->tready.
- tvalid=0 cycles between or within a job are allowed in any state; state and registers hold.

## Structure
- aes_pkg: DATA_W/ID_W defaults, rx_state_t enum (S_TEXT, S_KEY, S_ISSUE), rx_err_t enum (ERR_NONE, ERR_EARLY_LAST, ERR_NO_LAST, ERR_ID_MISMATCH).
- Single module; no sub-module. Integrates in place of direct core connection, between stream source and aes core.

## Test plan
- Nominal: beat1 tid=1 tlast=0 tdata=ae2d8a571e03ac9c9eb76fac45af8e51, beat2 tid=1 tlast=1 tdata=2b7e151628aed2a6abf7158809cf4f3c, job_ready=1 -> job_valid one cycle, job_id=1, text/key equal the beats, no err_pulse.
- Backpressure: job_ready=0 for 5 cycles -> job_valid held, outputs stable, tready=0 throughout; job_ready=1 -> tready=1 next cycle.
- Early tlast: single beat tid=2 tlast=1 -> err_pulse once, err_code=01, err_count=1, no job; following nominal pair issues normally.
- Missing tlast: three beats tlast=0,0,1 tid=3 with data A,B,K -> one error code 10, single job text=B key=K.
- Id mismatch: text tid=4, key tid=5 -> err_code=11, no job, state back to S_TEXT.
- Reset in S_ISSUE and err_count saturation (CNT_W=2, 5 errors -> count 3) -> all outputs at reset values, counter holds at max.
